// File: rtl/bpsk_demodulator_pkg.sv
// Shared types and helpers for the BPSK demodulator.
// Optional feature macro (see top): BPSK_DEMOD_DIFF_EN.
package bpsk_demod_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } demod_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // The sum of SPS centred samples needs log2(SPS) growth bits on top of the sign bit.
    function automatic int acc_width(input int data_width, input int sps);
        return data_width + 1 + $clog2(sps);
    endfunction

endpackage

// File: rtl/bpsk_demodulator_if.sv
// Sample-in / decision-out bundle between the channel side and the demodulator.
interface bpsk_demod_if #(
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_valid;
    logic                  bit_out;
    logic                  bit_valid;
    logic [7:0]            byte_out;
    logic                  byte_valid;
    logic                  frame_active;
    logic                  frame_err;

    modport master (
        output sample_in,
        output sample_valid,
        input  bit_out,
        input  bit_valid,
        input  byte_out,
        input  byte_valid,
        input  frame_active,
        input  frame_err
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output bit_out,
        output bit_valid,
        output byte_out,
        output byte_valid,
        output frame_active,
        output frame_err
    );
endinterface

// File: rtl/bpsk_demodulator_correlator.sv
// Integrate-and-dump of offset-binary samples against a square-wave carrier reference.
// o_sum/o_dump are combinational so the caller can register the decision one cycle after the last sample.
module symbol_correlator
    import bpsk_demod_pkg::*;
#(
    parameter int DATA_WIDTH         = 12,
    parameter int SAMPLES_PER_SYMBOL = 32,
    parameter int ACC_W              = acc_width(DATA_WIDTH, SAMPLES_PER_SYMBOL)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   i_sample,
    input  logic                    i_valid,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_dump
);
    localparam int PW = $clog2(SAMPLES_PER_SYMBOL);

    logic [PW-1:0]           r_phase;
    logic signed [ACC_W-1:0] r_acc;

    logic signed [DATA_WIDTH:0] w_centered;
    logic signed [ACC_W-1:0]    w_ext;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_sum;
    logic                       w_first_half;
    logic                       w_last;

    assign w_centered   = $signed({1'b0, i_sample}) - $signed({2'b01, {(DATA_WIDTH-1){1'b0}}});
    assign w_ext        = {{(ACC_W-DATA_WIDTH-1){w_centered[DATA_WIDTH]}}, w_centered};
    assign w_first_half = (r_phase < PW'(SAMPLES_PER_SYMBOL / 2));
    assign w_term       = w_first_half ? w_ext : -w_ext;
    assign w_sum        = r_acc + w_term;
    assign w_last       = (r_phase == PW'(SAMPLES_PER_SYMBOL - 1));

    assign o_sum  = w_sum;
    assign o_dump = i_valid && w_last;

    // The dumping sample is folded into w_sum, and the accumulator restarts at zero for the next symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_acc   <= '0;
        end else if (i_valid) begin
            if (w_last) begin
                r_phase <= '0;
                r_acc   <= '0;
            end else begin
                r_phase <= r_phase + PW'(1);
                r_acc   <= w_sum;
            end
        end
    end

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK receiver: correlator, slicer, optional differential decoder, sync hunt and byte framing.
// Define BPSK_DEMOD_DIFF_EN for differential decoding (bit = raw XOR previous raw).
//
//   state  | meaning
//   HUNT   | shifting bits, waiting for SYNC_BYTE; squelch ignored
//   LOCKED | assembling FRAME_BYTES payload bytes; weak symbol aborts
module bpsk_demodulator
    import bpsk_demod_pkg::*;
#(
    parameter int         DATA_WIDTH         = 12,
    parameter int         SAMPLES_PER_SYMBOL = 32,
    parameter logic [7:0] SYNC_BYTE          = DEFAULT_SYNC_BYTE,
    parameter int         FRAME_BYTES        = 4,
    parameter int         SQUELCH_MIN        = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    bpsk_demod_if.slave  bus
);
    localparam int ACC_W = acc_width(DATA_WIDTH, SAMPLES_PER_SYMBOL);
    localparam logic signed [ACC_W-1:0] SQ_MIN = ACC_W'(SQUELCH_MIN);

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_abs;
    logic                    w_dump;
    logic                    w_raw;
    logic                    w_bit;
    logic                    w_quiet;
    logic [7:0]              w_shifted;

    demod_state_e r_state, w_state_nxt;
    logic [7:0]   r_shift, w_shift_nxt;
    logic [2:0]   r_bitcnt, w_bitcnt_nxt;
    logic [7:0]   r_bytecnt, w_bytecnt_nxt;
    logic [7:0]   r_byte_out, w_byte_nxt;
    logic         w_byte_valid_nxt;
    logic         w_frame_err_nxt;

    logic r_bit_out;
    logic r_bit_valid;
    logic r_byte_valid;
    logic r_frame_err;

    symbol_correlator #(
        .DATA_WIDTH         (DATA_WIDTH),
        .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL),
        .ACC_W              (ACC_W)
    ) u_corr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sample (bus.sample_in),
        .i_valid  (bus.sample_valid),
        .o_sum    (w_sum),
        .o_dump   (w_dump)
    );

    // Zero correlation slices as 1.
    assign w_raw   = ~w_sum[ACC_W-1];
    assign w_abs   = w_sum[ACC_W-1] ? -w_sum : w_sum;
    assign w_quiet = (w_abs < SQ_MIN);

`ifdef BPSK_DEMOD_DIFF_EN
    logic r_prev_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_raw <= 1'b0;
        end else if (w_dump) begin
            r_prev_raw <= w_raw;
        end
    end

    assign w_bit = w_raw ^ r_prev_raw;
`else
    assign w_bit = w_raw;
`endif

    assign w_shifted = {r_shift[6:0], w_bit};

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bitcnt_nxt     = r_bitcnt;
        w_bytecnt_nxt    = r_bytecnt;
        w_byte_nxt       = r_byte_out;
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        if (w_dump) begin
            case (r_state)
                HUNT: begin
                    w_shift_nxt = w_shifted;
                    if (w_shifted == SYNC_BYTE) begin
                        w_state_nxt   = LOCKED;
                        w_bitcnt_nxt  = '0;
                        w_bytecnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (w_quiet) begin
                        w_state_nxt     = HUNT;
                        w_frame_err_nxt = 1'b1;
                        w_shift_nxt     = '0;
                        w_bitcnt_nxt    = '0;
                    end else begin
                        w_shift_nxt  = w_shifted;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_byte_valid_nxt = 1'b1;
                            w_byte_nxt       = w_shifted;
                            w_bytecnt_nxt    = r_bytecnt + 8'd1;
                            if (r_bytecnt == 8'(FRAME_BYTES - 1)) begin
                                w_state_nxt = HUNT;
                                w_shift_nxt = '0;
                            end
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_bytecnt    <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_bytecnt    <= w_bytecnt_nxt;
            r_byte_out   <= w_byte_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_bit_valid  <= w_dump;
            if (w_dump) begin
                r_bit_out <= w_bit;
            end
        end
    end

    assign bus.bit_out      = r_bit_out;
    assign bus.bit_valid    = r_bit_valid;
    assign bus.byte_out     = r_byte_out;
    assign bus.byte_valid   = r_byte_valid;
    assign bus.frame_active = (r_state == LOCKED);
    assign bus.frame_err    = r_frame_err;

endmodule
